// File: rtl/menu_select_overlay_if.sv
// menu_select_overlay_if
//   Bundles the pixel-path and game-FSM signals of the menu overlay.
//   master : game side (drives scan position, keys, labels; receives rgb/strobe)
//   slave  : the overlay itself
// Signals:
//   x, y          current pixel position
//   key_pulse     single-cycle key code, 0 = no key
//   active        overlay enabled by the game FSM
//   title_chars   7-bit char codes of the title, char 0 in bits [6:0]
//   opt_chars     option labels, option i char j at [7*(i*OPT_LEN+j) +: 7]
//   rgb           registered pixel colour
//   sel_valid     one-cycle confirm strobe
//   sel_idx       chosen option index
interface menu_select_overlay_if #(
  parameter int NUM_OPT   = 2,
  parameter int TITLE_LEN = 11,
  parameter int OPT_LEN   = 7
);
  localparam int IDX_W = (NUM_OPT > 2) ? $clog2(NUM_OPT) : 1;

  logic [9:0]                   x;
  logic [9:0]                   y;
  logic [4:0]                   key_pulse;
  logic                         active;
  logic [7*TITLE_LEN-1:0]       title_chars;
  logic [7*NUM_OPT*OPT_LEN-1:0] opt_chars;
  logic [2:0]                   rgb;
  logic                         sel_valid;
  logic [IDX_W-1:0]             sel_idx;

  modport master (
    output x, y, key_pulse, active, title_chars, opt_chars,
    input  rgb, sel_valid, sel_idx
  );

  modport slave (
    input  x, y, key_pulse, active, title_chars, opt_chars,
    output rgb, sel_valid, sel_idx
  );
endinterface

// File: rtl/menu_select_overlay.sv
// menu_select_overlay
//   Menu / end-of-stage overlay: draws a title and NUM_OPT option labels
//   from an 8x16 font ROM, a red frame around the highlighted option, and
//   issues a registered one-cycle selection strobe on confirm.
//   Pixel latency is 2 clocks from x/y to rgb.
// Ports:
//   clk    pixel clock
//   rst_n  asynchronous active-low reset
//   bus    menu_select_overlay_if.slave (x, y, key_pulse, active,
//          title_chars, opt_chars in; rgb, sel_valid, sel_idx out)
// Optional build macro:
//   BOX_BLINK_EN  blinks the selection frame with period 2**BLINK_LOG2 frames
module menu_select_overlay #(
  parameter int         NUM_OPT   = 2,
  parameter int         TITLE_LEN = 11,
  parameter int         OPT_LEN   = 7,
  parameter int         TITLE_X   = 280,
  parameter int         TITLE_Y   = 100,
  parameter int         OPT_X0    = 240,
  parameter int         OPT_PITCH = 120,
  parameter int         OPT_Y     = 340,
  parameter logic [4:0] KEY_NEXT  = 5'h1e,
  parameter logic [4:0] KEY_PREV  = 5'h1c,
  parameter logic [4:0] KEY_OK    = 5'h1d,
  parameter logic [2:0] TEXT_RGB  = 3'b001,
  parameter logic [2:0] BOX_RGB   = 3'b100,
  parameter logic [2:0] BG_RGB    = 3'b111
`ifdef BOX_BLINK_EN
  ,parameter int        BLINK_LOG2 = 5
`endif
) (
  input logic                 clk,
  input logic                 rst_n,
  menu_select_overlay_if.slave bus
);

  localparam int IDX_W = (NUM_OPT > 2) ? $clog2(NUM_OPT) : 1;
  localparam int OPT_W = 8 * OPT_LEN;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Small built-in glyph set; codes without a glyph render blank.
  function automatic logic [7:0] font_rom(input logic [10:0] addr);
    logic [7:0] w;
    case (addr[10:4])
      7'h41: begin // 'A'
        case (addr[3:0])
          4'd2:    w = 8'h10;
          4'd3:    w = 8'h38;
          4'd4:    w = 8'h6c;
          4'd5:    w = 8'hc6;
          4'd6:    w = 8'hc6;
          4'd7:    w = 8'hfe;
          4'd8:    w = 8'hc6;
          4'd9:    w = 8'hc6;
          4'd10:   w = 8'hc6;
          4'd11:   w = 8'hc6;
          default: w = 8'h00;
        endcase
      end
      7'h4f: begin // 'O'
        case (addr[3:0])
          4'd2:    w = 8'h7c;
          4'd11:   w = 8'h7c;
          4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: w = 8'hc6;
          default: w = 8'h00;
        endcase
      end
      7'h7f:   w = 8'hff; // solid block
      default: w = 8'h00;
    endcase
    return w;
  endfunction

  // FSM / selection state
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] cursor_q, cursor_d;
  logic             sel_valid_q, sel_valid_d;
  logic [IDX_W-1:0] sel_idx_q, sel_idx_d;

  // Stage 0 combinational decode
  int         xi, yi, dx, ox, bx;
  logic       title_on_s, opt_on_s, frame_s, box_on_s;
  logic [6:0] char_s;
  logic [3:0] row_s;
  logic [2:0] bit_s;

  // Stage 0 registers (alongside the ROM read)
  logic       title_on_q, opt_on_q, box_on_q;
  logic [2:0] bit_q;
  logic [7:0] font_word_q;

  // Stage 1
  logic       font_bit_s;
  logic [2:0] rgb_q, rgb_d;

`ifdef BOX_BLINK_EN
  logic [BLINK_LOG2-1:0] blink_q, blink_d;
`endif

  // Region decode, character/row/bit addressing and frame geometry
  always_comb begin
    title_on_s = 1'b0;
    opt_on_s   = 1'b0;
    frame_s    = 1'b0;
    char_s     = 7'd0;
    row_s      = 4'd0;
    bit_s      = 3'd0;
    dx         = 0;
    ox         = 0;
    xi         = int'(bus.x);
    yi         = int'(bus.y);
    bx         = OPT_X0 + int'(cursor_q) * OPT_PITCH;
    if (bus.active) begin
      if (xi >= TITLE_X && xi < TITLE_X + 8*TITLE_LEN &&
          yi >= TITLE_Y && yi < TITLE_Y + 16) begin
        dx         = xi - TITLE_X;
        title_on_s = 1'b1;
        char_s     = bus.title_chars[7*(dx >> 3) +: 7];
        row_s      = 4'(yi - TITLE_Y);
        bit_s      = 3'(dx);
      end else begin
        for (int i = 0; i < NUM_OPT; i++) begin
          ox = OPT_X0 + i * OPT_PITCH;
          if (xi >= ox && xi < ox + OPT_W && yi >= OPT_Y && yi < OPT_Y + 16) begin
            dx       = xi - ox;
            opt_on_s = 1'b1;
            char_s   = bus.opt_chars[7*(i*OPT_LEN + (dx >> 3)) +: 7];
            row_s    = 4'(yi - OPT_Y);
            bit_s    = 3'(dx);
          end else begin
            dx = dx;
          end
        end
      end
      // Frame: two 3-pixel horizontal bars and two 3-pixel vertical bars.
      frame_s = ((xi >= bx - 5 && xi <= bx + OPT_W + 5) &&
                 ((yi >= OPT_Y - 7 && yi <= OPT_Y - 5) ||
                  (yi >= OPT_Y + 20 && yi <= OPT_Y + 22))) ||
                (((xi >= bx - 7 && xi <= bx - 5) ||
                  (xi >= bx + OPT_W + 5 && xi <= bx + OPT_W + 7)) &&
                 (yi >= OPT_Y - 5 && yi <= OPT_Y + 21));
    end else begin
      title_on_s = 1'b0;
      opt_on_s   = 1'b0;
      frame_s    = 1'b0;
    end
  end

`ifdef BOX_BLINK_EN
  assign box_on_s = frame_s & ~blink_q[BLINK_LOG2-1];
`else
  assign box_on_s = frame_s;
`endif

  // Stage 0 pipeline registers and synchronous font ROM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      title_on_q  <= 1'b0;
      opt_on_q    <= 1'b0;
      box_on_q    <= 1'b0;
      bit_q       <= 3'd0;
      font_word_q <= 8'd0;
    end else begin
      title_on_q  <= title_on_s;
      opt_on_q    <= opt_on_s;
      box_on_q    <= box_on_s;
      bit_q       <= bit_s;
      font_word_q <= font_rom({char_s, row_s});
    end
  end

  // Glyph column 0 is the MSB of the font word.
  assign font_bit_s = font_word_q[~bit_q];

  // Stage 1 colour priority: text over frame over background
  always_comb begin
    if (font_bit_s && (title_on_q || opt_on_q)) begin
      rgb_d = TEXT_RGB;
    end else if (box_on_q) begin
      rgb_d = BOX_RGB;
    end else begin
      rgb_d = BG_RGB;
    end
  end

  // Stage 1 colour register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= BG_RGB;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  // Cursor/select next-state; dropping active wins over any key
  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    sel_idx_d   = sel_idx_q;
    sel_valid_d = 1'b0;
    if (!bus.active) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_ARMED;
          cursor_d = '0;
        end
        ST_ARMED: begin
          if (bus.key_pulse == KEY_NEXT) begin
            cursor_d = (cursor_q == IDX_W'(NUM_OPT-1)) ? '0 : cursor_q + IDX_W'(1);
          end else if (bus.key_pulse == KEY_PREV) begin
            cursor_d = (cursor_q == '0) ? IDX_W'(NUM_OPT-1) : cursor_q - IDX_W'(1);
          end else if (bus.key_pulse == KEY_OK) begin
            sel_valid_d = 1'b1;
            sel_idx_d   = cursor_q;
            state_d     = ST_LOCKED;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_LOCKED: state_d = ST_LOCKED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Cursor/select state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cursor_q    <= '0;
      sel_valid_q <= 1'b0;
      sel_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      sel_valid_q <= sel_valid_d;
      sel_idx_q   <= sel_idx_d;
    end
  end

`ifdef BOX_BLINK_EN
  // Frame counter: restarts on arming or cursor move so the frame shows at once
  always_comb begin
    if ((state_q == ST_IDLE && state_d == ST_ARMED) || (cursor_d != cursor_q)) begin
      blink_d = '0;
    end else if (bus.x == 10'd0 && bus.y == 10'd0) begin
      blink_d = blink_q + 1'b1;
    end else begin
      blink_d = blink_q;
    end
  end

  // Frame counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end
`endif

  assign bus.rgb       = rgb_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.sel_idx   = sel_idx_q;

endmodule

// File: tb/tb_menu_select_overlay.sv
// tb_menu_select_overlay
//   Directed bench for menu_select_overlay with NUM_OPT=3 and default
//   geometry. Option 0 label starts with a solid block then 'A'; title
//   starts with 'O'. Frame position is used to observe the cursor.
module tb_menu_select_overlay;

  localparam logic [2:0] TXT = 3'b001;
  localparam logic [2:0] BOX = 3'b100;
  localparam logic [2:0] BG  = 3'b111;
  localparam logic [4:0] K_NEXT = 5'h1e;
  localparam logic [4:0] K_PREV = 5'h1c;
  localparam logic [4:0] K_OK   = 5'h1d;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  menu_select_overlay_if #(.NUM_OPT(3), .TITLE_LEN(11), .OPT_LEN(7)) bus_if ();

  menu_select_overlay #(.NUM_OPT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a pixel, wait the 2-clock pipeline, compare rgb.
  task automatic pix(input int px, input int py, input logic [2:0] exp, input string tag);
    @(negedge clk);
    bus_if.x = 10'(px);
    bus_if.y = 10'(py);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk(tag, {5'd0, bus_if.rgb}, {5'd0, exp});
  endtask

  // Frame sits only around option c (left vertical bar probe at ox-6, OPT_Y).
  task automatic chk_cursor(input int c, input string tag);
    for (int i = 0; i < 3; i++) begin
      pix(234 + 120*i, 340, (i == c) ? BOX : BG, tag);
    end
  endtask

  task automatic press(input logic [4:0] k);
    @(negedge clk);
    bus_if.key_pulse = k;
    @(negedge clk);
    bus_if.key_pulse = 5'd0;
  endtask

  initial begin
    int ys[6];
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_if.x = 10'd0;
    bus_if.y = 10'd0;
    bus_if.key_pulse = 5'd0;
    bus_if.active = 1'b0;
    bus_if.title_chars = '0;
    bus_if.opt_chars   = '0;
    bus_if.title_chars[6:0] = 7'h4f;
    bus_if.opt_chars[6:0]   = 7'h7f;
    bus_if.opt_chars[13:7]  = 7'h41;

    repeat (3) @(negedge clk);
    chk("reset_rgb", {5'd0, bus_if.rgb}, {5'd0, BG});
    chk("reset_sel_valid", {7'd0, bus_if.sel_valid}, 8'd0);
    chk("reset_sel_idx", {6'd0, bus_if.sel_idx}, 8'd0);
    rst_n = 1'b1;

    // Inactive overlay: scan rows crossing title, labels and frame.
    ys = '{0, 100, 103, 335, 340, 345};
    for (int r = 0; r < 6; r++) begin
      for (int px = 0; px < 640; px++) begin
        @(negedge clk);
        bus_if.x = 10'(px);
        bus_if.y = 10'(ys[r]);
        chk("idle_rgb", {5'd0, bus_if.rgb}, {5'd0, BG});
        chk("idle_sel_valid", {7'd0, bus_if.sel_valid}, 8'd0);
      end
    end

    // Activate: cursor starts at 0.
    @(negedge clk);
    bus_if.active = 1'b1;
    @(negedge clk);
    chk_cursor(0, "cursor_after_arm");

    // Text pixels and frame boundaries with cursor 0.
    pix(240, 343, TXT, "opt0_block_bit");
    pix(251, 347, TXT, "opt0_A_row7_set");
    pix(255, 347, BG,  "opt0_A_row7_clear");
    pix(280, 103, TXT, "title_O_set");
    pix(283, 103, BG,  "title_O_clear");
    pix(232, 340, BG,  "frame0_left_outside");
    pix(301, 333, BOX, "frame0_top_right_corner");
    pix(302, 333, BG,  "frame0_top_past_corner");
    pix(240, 362, BOX, "frame0_bottom_bar");
    pix(240, 363, BG,  "frame0_below_bottom");

    // Cursor walk with wrap in both directions.
    press(K_NEXT);
    chk_cursor(1, "cursor_next1");
    press(K_NEXT);
    chk_cursor(2, "cursor_next2");
    press(K_NEXT);
    chk_cursor(0, "cursor_next_wrap");
    press(K_PREV);
    chk_cursor(2, "cursor_prev_wrap");
    pix(473, 345, BOX, "frame2_left_edge");
    pix(543, 345, BOX, "frame2_right_edge");
    pix(472, 345, BG,  "frame2_left_outside");
    pix(544, 345, BG,  "frame2_right_outside");
    press(5'h01);
    chk_cursor(2, "cursor_other_key");
    press(K_PREV);
    chk_cursor(1, "cursor_prev1");

    // Confirm option 1: one-cycle strobe.
    press(K_OK);
    chk("ok_strobe", {7'd0, bus_if.sel_valid}, 8'd1);
    chk("ok_idx", {6'd0, bus_if.sel_idx}, 8'd1);
    @(negedge clk);
    chk("ok_strobe_one_cycle", {7'd0, bus_if.sel_valid}, 8'd0);

    // Locked: keys ignored.
    press(K_OK);
    chk("locked_ok_ignored", {7'd0, bus_if.sel_valid}, 8'd0);
    press(K_NEXT);
    chk("locked_next_valid", {7'd0, bus_if.sel_valid}, 8'd0);
    chk_cursor(1, "locked_cursor_held");
    chk("locked_idx_held", {6'd0, bus_if.sel_idx}, 8'd1);

    // Re-arm, move to 1, then OK coinciding with active dropping.
    @(negedge clk);
    bus_if.active = 1'b0;
    @(negedge clk);
    bus_if.active = 1'b1;
    @(negedge clk);
    chk_cursor(0, "rearm_cursor");
    press(K_NEXT);
    chk_cursor(1, "rearm_next");
    @(negedge clk);
    bus_if.active = 1'b0;
    bus_if.key_pulse = K_OK;
    @(negedge clk);
    bus_if.key_pulse = 5'd0;
    chk("drop_ok_no_strobe", {7'd0, bus_if.sel_valid}, 8'd0);
    @(negedge clk);
    chk("drop_ok_no_strobe_later", {7'd0, bus_if.sel_valid}, 8'd0);
    pix(354, 340, BG, "inactive_no_frame");
    pix(240, 343, BG, "inactive_no_text");

    // Reactivate: cursor 0 and OK accepted.
    @(negedge clk);
    bus_if.active = 1'b1;
    @(negedge clk);
    chk_cursor(0, "react_cursor");
    press(K_OK);
    chk("react_ok_strobe", {7'd0, bus_if.sel_valid}, 8'd1);
    chk("react_ok_idx", {6'd0, bus_if.sel_idx}, 8'd0);

    // Select option 2, then reset in the cycle of a pending OK.
    @(negedge clk);
    bus_if.active = 1'b0;
    @(negedge clk);
    bus_if.active = 1'b1;
    @(negedge clk);
    press(K_NEXT);
    press(K_NEXT);
    press(K_OK);
    chk("sel2_strobe", {7'd0, bus_if.sel_valid}, 8'd1);
    chk("sel2_idx", {6'd0, bus_if.sel_idx}, 8'd2);
    @(negedge clk);
    bus_if.active = 1'b0;
    @(negedge clk);
    bus_if.active = 1'b1;
    bus_if.x = 10'd234;
    bus_if.y = 10'd340;
    @(negedge clk);
    press(K_NEXT);
    @(negedge clk);
    bus_if.key_pulse = K_OK;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    bus_if.key_pulse = 5'd0;
    chk("rst_strobe_lost", {7'd0, bus_if.sel_valid}, 8'd0);
    chk("rst_sel_idx", {6'd0, bus_if.sel_idx}, 8'd0);
    chk("rst_rgb", {5'd0, bus_if.rgb}, {5'd0, BG});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_cursor(0, "post_rst_cursor");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/menu_select_overlay.md
Name: menu_select_overlay

Overview:
Parametrised end-of-stage / menu overlay. Renders one title string and NUM_OPT option labels from the shared 8x16 font ROM, draws a red selection frame around the highlighted option, and moves the cursor with key pulses. On confirm it issues a registered one-cycle selection strobe to the game FSM. It sits in the VGA pixel path between the x/y scan counters and the rgb mux, and replaces per-stage hard-coded die/clear screens.

Parameters:
NUM_OPT, 2, number of selectable options (2..4)
TITLE_LEN, 11, title length in characters
OPT_LEN, 7, characters per option label (shorter labels are padded with char code 0)
TITLE_X, 280, title left pixel
TITLE_Y, 100, title top pixel
OPT_X0, 240, left pixel of option 0
OPT_PITCH, 120, x distance between option origins (must be ≥ 8*OPT_LEN+16)
OPT_Y, 340, option row top pixel
KEY_NEXT, 5'h1e, key code that advances the cursor
KEY_PREV, 5'h1c, key code that moves the cursor back
KEY_OK, 5'h1d, key code that confirms
TEXT_RGB, 3'b001, text colour
BOX_RGB, 3'b100, frame colour
BG_RGB, 3'b111, background colour
BLINK_LOG2, 5, frame-blink period exponent (used only with the optional feature)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
x  in  10  current pixel x
y  in  10  current pixel y
key_pulse  in  5  single-cycle key code; 0 = no key
active  in  1  overlay enabled by the game FSM
title_chars  in  7*TITLE_LEN  title char codes; char 0 in bits [6:0]
opt_chars  in  7*NUM_OPT*OPT_LEN  option labels; option i char j at bits [7*(i*OPT_LEN+j) +: 7]
rgb  out  3  registered pixel colour
sel_valid  out  1  one-cycle confirm strobe
sel_idx  out  IDX_W  chosen option index, IDX_W = max(1, clog2(NUM_OPT))

Behaviour:
- Reset: cursor=0, locked=0, sel_valid=0, sel_idx=0, rgb=BG_RGB, all pipeline registers 0.
- Pixel pipeline, 2 cycles from x/y to rgb:
  - Stage 0 (combinational, then registered): region decode (title_on, opt_on[i], box_on), char_addr, row_addr = y-origin, bit_addr = (x-origin)%8. rom_addr = {char_addr,row_addr}. Flags and bit_addr are registered alongside the ROM read.
  - Stage 1: font_bit = font_word[~bit_addr_q]; rgb register loads TEXT_RGB if font_bit & (title_on_q | opt_on_q); else BOX_RGB if box_on_q; else BG_RGB.
  - When active=0, stage 0 forces all flags to 0, so rgb is BG_RGB after 2 cycles.
- Frame geometry for selected option i (ox = OPT_X0+i*OPT_PITCH, w = 8*OPT_LEN):
  - horizontal bars: x in [ox-5, ox+w+5], y in [OPT_Y-7, OPT_Y-5] or [OPT_Y+20, OPT_Y+22]
  - vertical bars: x in [ox-7, ox-5] or [ox+w+5, ox+w+7], y in [OPT_Y-5, OPT_Y+21]
  - all bounds inclusive
- Cursor/select FSM, states IDLE, ARMED, LOCKED:
  - IDLE→ARMED when active=1; cursor cleared to 0 on that edge.
  - ARMED: KEY_NEXT gives cursor = (cursor==NUM_OPT-1) ? 0 : cursor+1. KEY_PREV gives cursor = (cursor==0) ? NUM_OPT-1 : cursor-1. KEY_OK gives sel_valid=1 for exactly one cycle, sel_idx=cursor, then → LOCKED.
  - LOCKED: all keys ignored; cursor and sel_idx held.
  - Any state with active=0 → IDLE next cycle; sel_valid stays 0. This overrides a KEY_OK in the same cycle.
  - Keys with any other code are ignored. Keys are ignored in IDLE.
- Cursor changes take effect on the frame from the next clock; no vsync alignment.
- Reset asserted mid-frame or mid-select: everything returns to reset values immediately. A pending strobe is lost.

Optional Feature:
BOX_BLINK_EN
- Defined: a frame counter increments when x==0 && y==0 and resets on rst_n or on entering ARMED. box_on is gated with ~counter[BLINK_LOG2-1] so the frame blinks. Any cursor move clears the counter, so the frame is visible immediately.
- Undefined: the frame is always visible; no counter exists.

Test Plan:
- Reset release with active=0, scan the full frame → every rgb=3'b111; sel_valid never asserted.
- active=1, NUM_OPT=3, three KEY_NEXT pulses → cursor 1,2,0. Then KEY_PREV → cursor 2; frame drawn around option 2 at x=ox-7..ox+w+7.
- Pixel (x=OPT_X0, y=OPT_Y+3) on a set font bit → rgb=3'b001 exactly 2 clocks later. Pixel (OPT_X0-6, OPT_Y) with cursor 0 → 3'b100.
- Cursor=1, KEY_OK → sel_valid=1 for one cycle, sel_idx=1. A second KEY_OK and KEY_NEXT are ignored; sel_valid stays 0.
- KEY_OK in the same cycle active drops to 0 → sel_valid stays 0. Reactivation → cursor=0 and KEY_OK is accepted again.
- With BOX_BLINK_EN, BLINK_LOG2=1: frame present on frame 0, absent on frame 1, present on frame 2. A KEY_NEXT during an off frame → frame visible on the next frame.
